// File: rtl/ls193_timer_ctrl.sv
// ls193_timer_ctrl: sequencer for a chain of cascaded ls193 up/down counters
// used as a programmable interval timer. Drives clear / parallel-load /
// count-down pins, watches the terminal borrow and reports expiry.
//
// Request semantics: tick_en is a single-cycle request with no ready
// handshake. It is consumed only when the sequencer sits in ARM. In IDLE it
// is silently ignored. In any other state it is dropped and flags ovr.
// start is honoured only in IDLE and never queued.
//
// Every output is a flop so nothing combinational reaches the TTL clock pins.
// Output values are loaded on the transition into a state, so the pins show
// a state's values for exactly the cycles the FSM sits in that state.
module ls193_timer_ctrl #(
    parameter int NIB     = 2,
    parameter int PULSE_W = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               one_shot,
    input  logic [4*NIB-1:0]   preload,
    input  logic               tick_en,
    input  logic               irq_ack,
    input  logic [4*NIB-1:0]   Q,
    input  logic               _BO,
    output logic               CLR,
    output logic               _LOAD,
    output logic [4*NIB-1:0]   LD,
    output logic               _UP,
    output logic               _DOWN,
    output logic               busy,
    output logic               done,
    output logic               irq,
    output logic               ovr,
    output logic               load_err,
    output logic [2:0]         state_dbg
);

    localparam int W  = 4 * NIB;
    // A zero or negative pulse width would make no edge at all; clamp to 1.
    localparam int PW = (PULSE_W < 1) ? 1 : PULSE_W;
    localparam int CW = (PW > 1) ? $clog2(PW) : 1;
    localparam logic [CW-1:0] PW_LAST = CW'(PW - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_VERIFY   = 3'd2,
        S_ARM      = 3'd3,
        S_PULSE_LO = 3'd4,
        S_PULSE_HI = 3'd5,
        S_EXPIRE   = 3'd6
    } state_t;

    state_t          state;
    logic            os_q;      // one_shot captured at start
    logic            exp_flag;  // borrow seen during the current count pulse
    logic [CW-1:0]   pw_cnt;    // remaining low cycles of _DOWN

    // The FSM state register is already a flop, so it is exposed directly.
    assign state_dbg = state;

    // Sequencer: state, pin drive and sticky status in one registered process.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            CLR      <= 1'b1;
            _LOAD    <= 1'b1;
            LD       <= '0;
            _UP      <= 1'b1;
            _DOWN    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            irq      <= 1'b0;
            ovr      <= 1'b0;
            load_err <= 1'b0;
            os_q     <= 1'b0;
            exp_flag <= 1'b0;
            pw_cnt   <= '0;
        end else begin
            // The chain only ever counts down.
            _UP  <= 1'b1;
            done <= 1'b0;

            // Acknowledge first so that an expiry in the same cycle
            // (irq <= 1 further down) takes precedence.
            if (irq_ack) begin
                irq <= 1'b0;
            end

            // A tick outside ARM cannot be honoured; IDLE is exempt because
            // the timer is not running and nobody expects the tick to count.
            if (tick_en && (state != S_IDLE) && (state != S_ARM)) begin
                ovr <= 1'b1;
            end

            if (stop && (state != S_IDLE)) begin
                // Abort: clear the counter. Releasing _DOWN here may give a
                // rising edge, but CLR is high at the same time and wins.
                state    <= S_IDLE;
                CLR      <= 1'b1;
                _DOWN    <= 1'b1;
                _LOAD    <= 1'b1;
                busy     <= 1'b0;
                exp_flag <= 1'b0;
                pw_cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        CLR   <= 1'b1;
                        _DOWN <= 1'b1;
                        _LOAD <= 1'b1;
                        busy  <= 1'b0;
                        // stop held together with start keeps us idle.
                        if (start && !stop) begin
                            LD       <= preload;
                            os_q     <= one_shot;
                            ovr      <= 1'b0;
                            load_err <= 1'b0;
                            CLR      <= 1'b0;
                            _LOAD    <= 1'b0;
                            busy     <= 1'b1;
                            state    <= S_LOAD;
                        end
                    end

                    S_LOAD: begin
                        // ls193 load is level sensitive; one cycle is enough.
                        _LOAD <= 1'b1;
                        state <= S_VERIFY;
                    end

                    S_VERIFY: begin
                        // The counter has held LD since the load pulse; a
                        // difference means a wiring or device fault. Keep
                        // running so the fault is observable on the pins.
                        if (Q != LD) begin
                            load_err <= 1'b1;
                        end
                        state <= S_ARM;
                    end

                    S_ARM: begin
                        if (tick_en) begin
                            _DOWN  <= 1'b0;
                            pw_cnt <= PW_LAST;
                            state  <= S_PULSE_LO;
                        end
                    end

                    S_PULSE_LO: begin
                        if (pw_cnt == '0) begin
                            // _BO is low only while the count is zero and
                            // _DOWN is low, i.e. this pulse wraps the count.
                            exp_flag <= ~_BO;
                            _DOWN    <= 1'b1;
                            state    <= S_PULSE_HI;
                        end else begin
                            pw_cnt <= pw_cnt - 1'b1;
                        end
                    end

                    S_PULSE_HI: begin
                        // The _DOWN rise has just decremented the counter.
                        if (exp_flag) begin
                            done  <= 1'b1;
                            state <= S_EXPIRE;
                        end else begin
                            state <= S_ARM;
                        end
                    end

                    S_EXPIRE: begin
                        irq      <= 1'b1;
                        exp_flag <= 1'b0;
                        if (os_q) begin
                            CLR   <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            // Auto-reload reuses the latched LD.
                            _LOAD <= 1'b0;
                            state <= S_LOAD;
                        end
                    end

                    default: begin
                        CLR   <= 1'b1;
                        _DOWN <= 1'b1;
                        _LOAD <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ls193_timer_ctrl.sv
// Testbench for ls193_timer_ctrl. A behavioural ls193 chain answers the
// controller's pins; a reference model predicts the event stream (load
// pulses, counter values after each count, expiries) into a queue that a
// monitor drains as the DUT produces the events.
module tb_ls193_timer_ctrl;

  localparam int NIB = 2;
  localparam int W   = 4 * NIB;
  localparam int PW  = 2;

  localparam logic [1:0] K_LOAD = 2'd1;
  localparam logic [1:0] K_TICK = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  // clock / reset and DUT wiring
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, one_shot = 1'b0;
  logic tick_en = 1'b0, irq_ack = 1'b0;
  logic [W-1:0] preload = '0;
  logic [W-1:0] q;
  logic bo_n;
  logic clr, load_n, up_n, down_n, busy, done, irq, ovr, load_err;
  logic [W-1:0] ld;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  ls193_timer_ctrl #(.NIB(NIB), .PULSE_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .one_shot(one_shot),
    .preload(preload), .tick_en(tick_en), .irq_ack(irq_ack),
    .Q(q), ._BO(bo_n), .CLR(clr), ._LOAD(load_n), .LD(ld), ._UP(up_n),
    ._DOWN(down_n), .busy(busy), .done(done), .irq(irq), .ovr(ovr),
    .load_err(load_err), .state_dbg(state_dbg)
  );

  // counter chain model (sampled just after each edge)
  logic [W-1:0] cnt_m = '0;
  logic prev_d = 1'b1;
  logic stuck = 1'b0;

  assign q    = stuck ? '0 : cnt_m;
  assign bo_n = ~((cnt_m == '0) && !down_n);

  always @(posedge clk) begin
    #1;
    if (clr) cnt_m = '0;
    else if (!load_n) cnt_m = ld;
    else if (down_n && !prev_d) cnt_m = cnt_m - 1'b1;
    prev_d = down_n;
  end

  // scoreboard state
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [W+1:0] exp_q[$];

  // reference model state
  logic m_active = 1'b0, m_os = 1'b0, m_irq = 1'b0, m_ovr = 1'b0;
  logic [W-1:0] m_p = '0, m_c = '0;
  int m_next_ok = 0;
  int m_idle_from = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic match(input logic [1:0] kind, input string name, input logic [W-1:0] act);
    logic [W+1:0] r;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: event seen with nothing expected, value %0h (cycle %0d)", name, act, cyc);
    end else begin
      r = exp_q.pop_front();
      check({name, "_kind"}, 32'(r[W+1:W]), 32'(kind));
      check(name, 32'(act), 32'(r[W-1:0]));
    end
  endtask

  // monitor: pops one expectation per observed event
  int lo_cnt = 0;
  logic mon_prev_d = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      lo_cnt = 0;
      mon_prev_d = 1'b1;
    end else begin
      if (!load_n) match(K_LOAD, "load_ld", ld);
      if (done) match(K_DONE, "done_q", cnt_m);
      if (down_n && !mon_prev_d && !clr) begin
        check("down_width", 32'(lo_cnt), 32'(PW));
        match(K_TICK, "tick_q", cnt_m);
      end
      lo_cnt = down_n ? 0 : lo_cnt + 1;
      mon_prev_d = down_n;
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_ok(input int extra);
    while (cyc < m_next_ok + extra) step();
  endtask

  task automatic wait_idle();
    while (cyc < m_idle_from) step();
  endtask

  task automatic do_start(input logic [W-1:0] p, input logic os);
    wait_idle();
    preload = p;
    one_shot = os;
    start = 1'b1;
    m_active = 1'b1;
    m_os = os;
    m_p = p;
    m_c = p;
    m_ovr = 1'b0;
    m_next_ok = cyc + 3;
    exp_q.push_back({K_LOAD, p});
    step();
    start = 1'b0;
  endtask

  // A tick counts when a full load/verify or pulse sequence has elapsed
  // since the previous accepted event; the period is preload+1 ticks.
  task automatic do_tick();
    int k;
    logic [W-1:0] old;
    k = cyc;
    tick_en = 1'b1;
    if (m_active && k >= m_next_ok) begin
      old = m_c;
      m_c = old - 1'b1;
      exp_q.push_back({K_TICK, m_c});
      if (old == '0) begin
        exp_q.push_back({K_DONE, m_c});
        m_irq = 1'b1;
        if (m_os) begin
          m_active = 1'b0;
          m_idle_from = k + PW + 3;
        end else begin
          m_c = m_p;
          exp_q.push_back({K_LOAD, m_p});
          m_next_ok = k + PW + 5;
        end
      end else begin
        m_next_ok = k + PW + 2;
      end
    end else if (m_active || k < m_idle_from) begin
      m_ovr = 1'b1;
    end
    step();
    tick_en = 1'b0;
  endtask

  task automatic do_stop();
    wait_ok(0);
    stop = 1'b1;
    m_active = 1'b0;
    m_idle_from = cyc + 1;
    step();
    stop = 1'b0;
  endtask

  task automatic ack_irq();
    irq_ack = 1'b1;
    m_irq = 1'b0;
    step();
    irq_ack = 1'b0;
    check("irq_ack_clear", 32'(irq), 32'd0);
  endtask

  task automatic end_checks(input string tag);
    wait_idle();
    step();
    step();
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_clr"}, 32'(clr), 32'd1);
    check({tag, "_up"}, 32'(up_n), 32'd1);
    check({tag, "_q_cleared"}, 32'(cnt_m), 32'd0);
    check({tag, "_irq"}, 32'(irq), 32'(m_irq));
    check({tag, "_ovr"}, 32'(ovr), 32'(m_ovr));
  endtask

  task automatic rand_run();
    logic [W-1:0] p;
    logic os;
    int n;
    p = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 5));
    os = 1'($urandom_range(0, 1));
    n = $urandom_range(1, 14);
    do_start(p, os);
    for (int i = 0; i < n; i++) begin
      if (!m_active) break;
      if ($urandom_range(0, 5) != 0) wait_ok($urandom_range(0, 2));
      do_tick();
    end
    if (m_active) do_stop();
    end_checks("rand");
    if ($urandom_range(0, 1) == 1) ack_irq();
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    int k;
    step();
    check("rst_clr", 32'(clr), 32'd1);
    check("rst_load_n", 32'(load_n), 32'd1);
    check("rst_up_n", 32'(up_n), 32'd1);
    check("rst_down_n", 32'(down_n), 32'd1);
    check("rst_ld", 32'(ld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    rst = 1'b0;
    step();

    // one-shot, preload 3, ticks spaced 5 cycles
    do_start(8'h03, 1'b1);
    check("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      wait_ok(1);
      do_tick();
    end
    end_checks("t1");
    ack_irq();

    // tick in IDLE is ignored and does not set ovr
    do_tick();
    step();
    check("idle_tick_ovr", 32'(ovr), 32'd0);
    check("idle_tick_busy", 32'(busy), 32'd0);

    // start together with stop in IDLE stays idle
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    step();
    check("start_stop_busy", 32'(busy), 32'd0);
    check("start_stop_load_n", 32'(load_n), 32'd1);

    // auto-reload, preload 0: every tick expires
    do_start(8'h00, 1'b0);
    wait_ok(0);
    do_tick();
    wait_ok(0);
    check("t2_irq_1", 32'(irq), 32'd1);
    ack_irq();
    wait_ok(0);
    do_tick();
    wait_ok(0);
    check("t2_irq_2", 32'(irq), 32'd1);
    step();
    step();
    step();
    check("t2_irq_sticky", 32'(irq), 32'd1);
    ack_irq();
    wait_ok(0);
    k = cyc;
    do_tick();
    while (cyc < k + PW + 2) step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("t2_irq_set_wins", 32'(irq), 32'd1);
    do_stop();
    end_checks("t2");

    // asynchronous reset mid-count (irq still set from above)
    do_start(8'h09, 1'b0);
    wait_ok(0);
    do_tick();
    do_tick();
    check("t6_pre_down_n", 32'(down_n), 32'd0);
    check("t6_pre_ovr", 32'(ovr), 32'd1);
    check("t6_pre_irq", 32'(irq), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_clr", 32'(clr), 32'd1);
    check("t6_load_n", 32'(load_n), 32'd1);
    check("t6_down_n", 32'(down_n), 32'd1);
    check("t6_ld", 32'(ld), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_irq", 32'(irq), 32'd0);
    check("t6_ovr", 32'(ovr), 32'd0);
    check("t6_load_err", 32'(load_err), 32'd0);
    exp_q.delete();
    m_active = 1'b0;
    m_irq = 1'b0;
    m_ovr = 1'b0;
    m_idle_from = 0;
    step();
    step();
    rst = 1'b0;
    check("t6_q_cleared", 32'(cnt_m), 32'd0);
    step();
    do_start(8'h10, 1'b1);
    for (int i = 0; i < 17; i++) begin
      wait_ok(0);
      do_tick();
    end
    end_checks("t6_run");
    ack_irq();

    // back-to-back ticks: only one counts, ovr set, cleared by next start
    do_start(8'h05, 1'b1);
    wait_ok(0);
    do_tick();
    do_tick();
    check("t3_ovr", 32'(ovr), 32'd1);
    do_stop();
    end_checks("t3");
    do_start(8'h05, 1'b1);
    check("t3_ovr_cleared", 32'(ovr), 32'd0);
    do_stop();
    end_checks("t3b");

    // readback fault: Q stuck at zero
    stuck = 1'b1;
    do_start(8'h5A, 1'b1);
    step();
    check("t4_load_err_early", 32'(load_err), 32'd0);
    step();
    check("t4_load_err", 32'(load_err), 32'd1);
    wait_ok(0);
    do_tick();
    wait_ok(0);
    do_tick();
    do_stop();
    end_checks("t4");
    check("t4_load_err_sticky", 32'(load_err), 32'd1);
    stuck = 1'b0;
    do_start(8'h05, 1'b1);
    step();
    step();
    check("t4_load_err_cleared", 32'(load_err), 32'd0);
    do_stop();
    end_checks("t4b");

    // stop during the low phase of a count pulse
    do_start(8'h07, 1'b1);
    wait_ok(0);
    tick_en = 1'b1;
    step();
    tick_en = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    m_active = 1'b0;
    m_idle_from = cyc;
    check("t5_clr", 32'(clr), 32'd1);
    check("t5_down_n", 32'(down_n), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    step();
    check("t5_q", 32'(cnt_m), 32'd0);
    check("t5_done_after", 32'(done), 32'd0);
    end_checks("t5");

    // full-range period: 2^W ticks
    do_start(8'hFF, 1'b1);
    for (int i = 0; i < 256; i++) begin
      wait_ok(0);
      do_tick();
    end
    end_checks("tff");
    ack_irq();

    // randomized runs
    for (int r = 0; r < 24; r++) rand_run();

    step();
    step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
